// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the per-stage control bundle and the
// helper that decodes an unfrozen cycle into stage controls.
package pipe_ctrl_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // One bit per pipeline-register control, MSB first.
    typedef struct packed {
        logic pc_stall;
        logic fd_stall;
        logic fd_flush;
        logic de_stall;
        logic de_flush;
        logic em_stall;
        logic mw_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = ctrl_t'(7'b000_0000);
    localparam ctrl_t CTRL_ALL    = ctrl_t'(7'b111_1111);
    // Front end idle: PC held, F/D and D/E filled with bubbles, no writeback.
    localparam ctrl_t CTRL_INIT   = ctrl_t'(7'b101_0101);
    // Whole pipe frozen around a pending dmem access; M/W drains a bubble.
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b110_1011);

    // Controls for a cycle where the memory side is not holding the pipe.
    // A redirect kills the younger instructions, so a load-use on them is moot.
    function automatic ctrl_t issue_ctrl(input logic redirect, input logic lu);
        ctrl_t c;
        c = CTRL_NONE;
        if (redirect) begin
            c.fd_flush = 1'b1;
            c.de_flush = 1'b1;
        end else if (lu) begin
            c.pc_stall = 1'b1;
            c.fd_stall = 1'b1;
            c.de_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// master: datapath side (drives decode/execute/dmem status, consumes controls).
// slave : hazard controller.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_redirect;
    logic                  mem_req;
    logic                  dmem_ready;

    logic                  pc_stall;
    logic                  fd_stall;
    logic                  fd_flush;
    logic                  de_stall;
    logic                  de_flush;
    logic                  em_stall;
    logic                  mw_bubble;
    logic                  mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_mem_read, ex_redirect, mem_req, dmem_ready,
        input  pc_stall, fd_stall, fd_flush, de_stall, de_flush,
        input  em_stall, mw_bubble, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_mem_read, ex_redirect, mem_req, dmem_ready,
        output pc_stall, fd_stall, fd_flush, de_stall, de_flush,
        output em_stall, mw_bubble, mem_timeout
    );

endinterface

// File: rtl/pipe_hazard_ctrl_haz_lu_det.sv
// Load-use detector: flags a decode instruction that reads the register a
// load in execute is about to write. x0 never creates a dependency.
module haz_lu_det
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  lu
);

    logic rd_valid;
    logic hit_rs1;
    logic hit_rs2;

    assign rd_valid = ex_mem_read & (ex_rd != '0);
    assign hit_rs1  = id_use_rs1 & (ex_rd == id_rs1);
    assign hit_rs2  = id_use_rs2 & (ex_rd == id_rs2);

    // Single-cycle combinational compare; result feeds the same-cycle stall.
    always_comb begin
        lu = rd_valid & (hit_rs1 | hit_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Resolves load-use hazards, execute-stage redirects and multi-cycle dmem
// waits, and holds the front end idle for RESET_HOLD cycles after reset.
// Optional feature macro: HAZ_PERF_CNT_EN adds perf_stall_cnt/perf_flush_cnt.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  INIT     | post-reset hold, PC stalled, F/D and D/E flushed, no inputs used
//  RUN      | normal issue; freeze > redirect > load-use
//  MEM_WAIT | dmem access outstanding, whole pipe frozen until dmem_ready
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RESET_HOLD  = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic [1:0] S_INIT     = 2'(INIT);
    localparam logic [1:0] S_RUN      = 2'(RUN);
    localparam logic [1:0] S_MEM_WAIT = 2'(MEM_WAIT);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(MEM_TIMEOUT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_set;
    logic             mem_timeout_q;
    logic             lu;
    logic             fz;
    ctrl_t            ctrl;

    haz_lu_det u_lu_det (
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_use_rs1  (hz.id_use_rs1),
        .id_use_rs2  (hz.id_use_rs2),
        .ex_rd       (hz.ex_rd),
        .ex_mem_read (hz.ex_mem_read),
        .lu          (lu)
    );

    assign fz = hz.mem_req & ~hz.dmem_ready;

    // Next state and counter: reset hold count in INIT, wait length in MEM_WAIT.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_set = 1'b0;
        case (state)
            S_INIT: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (fz) begin
                    state_nxt = S_MEM_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else if (cnt != TMO_MAX) begin
                    // Flag is raised on the same edge the count lands on the limit.
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == TMO_LAST) begin
                        timeout_set = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and sticky timeout flag; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_INIT;
            cnt           <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    // Same-cycle output decode; reset forces every stage to hold/bubble.
    always_comb begin
        ctrl = CTRL_NONE;
        if (!rst) begin
            ctrl = CTRL_ALL;
        end else begin
            case (state)
                S_INIT:     ctrl = CTRL_INIT;
                S_RUN:      ctrl = fz ? CTRL_FREEZE : issue_ctrl(hz.ex_redirect, lu);
                S_MEM_WAIT: ctrl = hz.dmem_ready ? issue_ctrl(hz.ex_redirect, lu)
                                                 : CTRL_FREEZE;
                default:    ctrl = CTRL_INIT;
            endcase
        end
    end

    assign hz.pc_stall    = ctrl.pc_stall;
    assign hz.fd_stall    = ctrl.fd_stall;
    assign hz.fd_flush    = ctrl.fd_flush;
    assign hz.de_stall    = ctrl.de_stall;
    assign hz.de_flush    = ctrl.de_flush;
    assign hz.em_stall    = ctrl.em_stall;
    assign hz.mw_bubble   = ctrl.mw_bubble;
    assign hz.mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic issuing;
    logic stall_evt;
    logic flush_evt;

    assign issuing   = ((state == S_RUN) & ~fz) | ((state == S_MEM_WAIT) & hz.dmem_ready);
    assign stall_evt = (state != S_INIT) & ctrl.pc_stall;
    assign flush_evt = issuing & hz.ex_redirect;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_evt) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush_evt) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
